// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file writeback scheduler merging ALU and buffered memory results
// Optional same-cycle memory bypass into an idle, empty write port: define RF_WB_BYPASS_EN.
module rf_wb_sched #(
    parameter int DEPTH      = 4,
    parameter int AW         = 6,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_we,
    input  logic [AW-1:0]            alu_dst_addr,
    input  logic [DW-1:0]            alu_dst,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_dst_addr,
    input  logic [DW-1:0]            mem_dst,
    output logic                     mem_ready,
    output logic                     we,
    output logic [AW-1:0]            dst_addr,
    output logic [DW-1:0]            dst,
    input  logic [AW-1:0]            chk_addr0,
    input  logic [AW-1:0]            chk_addr1,
    output logic                     pend0,
    output logic                     pend1,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    starve_cnt;

    logic             fifo_ne;
    logic             full;
    logic             starve;
    logic             mem_acc;
    logic             enq;
    logic             deq;
    logic             byp;
    logic             alu_issue;
    logic             nxt_we;
    logic [AW-1:0]    nxt_addr;
    logic [DW-1:0]    nxt_dst;
    logic [DEPTH-1:0] ent_valid;
    logic             hit0;
    logic             hit1;

    assign fifo_ne   = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign mem_ready = !full;
    assign mem_acc   = mem_valid && !full;
    assign starve    = fifo_ne && (starve_cnt == SW'(STARVE_MAX));
    assign alu_stall = starve;
    assign fifo_cnt  = cnt;

    // Port arbitration: starved FIFO head, then ALU, then FIFO head, then (optionally) bypass.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_addr  = dst_addr;
        nxt_dst   = dst;
        deq       = 1'b0;
        byp       = 1'b0;
        alu_issue = 1'b0;
        if (starve) begin
            deq      = 1'b1;
            nxt_we   = 1'b1;
            nxt_addr = q_addr[rd_ptr];
            nxt_dst  = q_data[rd_ptr];
        end else if (alu_we) begin
            // An r0 ALU write still takes the slot; it is simply not written.
            alu_issue = 1'b1;
            if (alu_dst_addr != '0) begin
                nxt_we   = 1'b1;
                nxt_addr = alu_dst_addr;
                nxt_dst  = alu_dst;
            end
        end else if (fifo_ne) begin
            deq      = 1'b1;
            nxt_we   = 1'b1;
            nxt_addr = q_addr[rd_ptr];
            nxt_dst  = q_data[rd_ptr];
        end else begin
`ifdef RF_WB_BYPASS_EN
            if (mem_acc && (mem_dst_addr != '0)) begin
                byp      = 1'b1;
                nxt_we   = 1'b1;
                nxt_addr = mem_dst_addr;
                nxt_dst  = mem_dst;
            end
`endif
        end
        enq = mem_acc && (mem_dst_addr != '0) && !byp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we         <= 1'b0;
            dst_addr   <= '0;
            dst        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
        end else begin
            we       <= nxt_we;
            dst_addr <= nxt_addr;
            dst      <= nxt_dst;
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (deq || !fifo_ne) begin
                starve_cnt <= '0;
            end else if (alu_issue && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= mem_dst_addr;
            q_data[wr_ptr] <= mem_dst;
        end
    end

    always_comb begin
        ent_valid = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < cnt);
            if (ent_valid[i] && (q_addr[i] == chk_addr0)) begin
                hit0 = 1'b1;
            end
            if (ent_valid[i] && (q_addr[i] == chk_addr1)) begin
                hit1 = 1'b1;
            end
        end
        pend0 = (chk_addr0 != '0) && (hit0 || (we && (dst_addr == chk_addr0)));
        pend1 = (chk_addr1 != '0) && (hit1 || (we && (dst_addr == chk_addr1)));
    end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Writeback scheduler that drives the single write port (we, dst_addr, dst) of the 64-entry x 16-bit register file.
- Merges two result producers onto that one port:
  - the single-cycle ALU path, fire-and-forget;
  - the multi-cycle memory/long-latency path, valid/ready handshake, buffered in a small FIFO.
- Reports pending writes so the hazard unit can stall dependent reads.

Parameters:
- DEPTH, 4: memory-path FIFO entries (power of 2, minimum 2).
- AW, 6: register address width.
- DW, 16: data width.
- STARVE_MAX, 3: consecutive cycles a non-empty FIFO may be blocked by ALU writes before it forces priority.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- alu_we  in  1  ALU result valid this cycle.
- alu_dst_addr  in  AW  ALU destination register.
- alu_dst  in  DW  ALU result.
- alu_stall  out  1  ALU write not accepted this cycle; upstream holds it.
- mem_valid  in  1  memory result offered.
- mem_dst_addr  in  AW  memory destination register.
- mem_dst  in  DW  memory result.
- mem_ready  out  1  FIFO can accept (= !full).
- we  out  1  register-file write enable (registered).
- dst_addr  out  AW  register-file write address (registered).
- dst  out  DW  register-file write data (registered).
- chk_addr0, chk_addr1  in  AW  read addresses to check.
- pend0, pend1  out  1  a write to chk_addrN is in flight.
- fifo_cnt  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at posedge):
  - we=0, dst_addr=0, dst=0.
  - FIFO empty: rd/wr pointers 0, fifo_cnt=0.
  - Starve counter 0, so alu_stall=0 and mem_ready=1 the cycle after reset.
  - Reset mid-operation discards all buffered entries. No write is issued on the cycle reset is sampled.
- R0 filter: any write with address 0 is dropped and never reaches we.
  - The ALU write is consumed; alu_stall is unaffected.
  - The memory handshake still completes (entry is not enqueued, fifo_cnt unchanged).
- Memory accept:
  - Accept occurs when mem_valid & mem_ready at posedge.
  - The entry is written at wr_ptr, which wraps modulo DEPTH.
  - mem_ready = (fifo_cnt != DEPTH). No enqueue when full, even if a dequeue occurs the same cycle.
- Port arbitration each cycle, in priority order:
  1. starve = (fifo_cnt != 0) & (starve_cnt == STARVE_MAX). If set: FIFO head issues, alu_stall=1 (combinational), ALU input ignored.
  2. Else, if alu_we: ALU write issues. If fifo_cnt != 0, starve_cnt increments, saturating at STARVE_MAX.
  3. Else, if fifo_cnt != 0: FIFO head issues.
  4. Else: we <= 0.
  - starve_cnt clears whenever the FIFO head issues or the FIFO is empty.
- Issue timing:
  - Issue loads we/dst_addr/dst at the posedge; the register file sees the write on the following cycle.
  - ALU latency: 1 cycle.
  - Memory latency (FIFO empty, no contention): 2 cycles (enqueue, then dequeue).
- fifo_cnt:
  - +1 on enqueue, -1 on dequeue, unchanged on simultaneous enqueue and dequeue.
- pend outputs (combinational):
  - pendN = 1 if chk_addrN != 0 and it matches any valid FIFO entry or (we & dst_addr).
  - chk_addrN = 0 always gives pendN = 0.
- Ordering:
  - Writes issue in the order they are granted.
  - WAW hazards between the two producers are excluded by the hazard unit using pend. The block does not reorder.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: when FIFO is empty, starve=0, alu_we=0 and a memory write is accepted, that write issues directly into we/dst_addr/dst at the same posedge without entering the FIFO. fifo_cnt stays 0 and memory latency is 1 cycle.
- Undefined: every memory write passes through the FIFO (latency 2 minimum).

Test Plan:
- Reset then alu_we=1, addr=5, data=16'hBEEF for one cycle -> next cycle we=1, dst_addr=5, dst=BEEF; following cycle we=0.
- mem write addr=9, data=16'h1234, FIFO empty, no ALU traffic -> we=1 with addr 9 two cycles after accept (one cycle with RF_WB_BYPASS_EN); fifo_cnt never exceeds 1 (stays 0 with bypass).
- Hold alu_we=1 continuously, then enqueue mem addr=7 -> ALU wins 3 cycles, 4th cycle alu_stall=1 and addr 7 issues, then ALU resumes with the held request.
- 5 back-to-back mem writes (addrs 1..5) while ALU writes every cycle -> mem_ready drops when fifo_cnt=4; all 5 eventually issue in order 1..5; no loss, no duplication.
- ALU addr=0 and mem addr=0 -> we never asserts for addr 0; mem handshake completes; fifo_cnt stays 0.
- Enqueue mem addr=12, drive chk_addr0=12, chk_addr1=0 -> pend0=1 until the cycle after the addr-12 write issues; pend1=0 throughout. Asserting rst_n=0 mid-queue -> fifo_cnt=0, pend0=0 next cycle.
